rv32_regfile_mp: RTL
====================

# rv32_regfile_mp

Parametrised multi-port integer register file for the 5-stage core. It generalises the single-write, dual-read file to NUM_RD read ports and NUM_WR write ports, with registered reads and per-port write-to-read bypass. Array initialisation is done by a sequential clear engine rather than a reset loop, so the storage can map to distributed RAM or BRAM. It sits between decode (read ports) and writeback (write ports).

## Interface

Parameters:
- XLEN, 32, data width in bits
- DEPTH, 32, number of registers (≥2); AW = $clog2(DEPTH)
- NUM_RD, 2, read ports (1–4)
- NUM_WR, 1, write ports (1–2)
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  one-cycle request to re-zero the whole array (honoured only when ready=1)
- ready  out  1  1 = array initialised, reads/writes accepted
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*AW  packed write addresses, port p at [p*AW +: AW]
- wr_data  in  NUM_WR*XLEN  packed write data
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*AW  packed read addresses
- rd_data  out  NUM_RD*XLEN  packed registered read data

## Operation

- FSM states: CLEAR, READY.
- rst asserted: state=CLEAR, clear pointer ptr=0, ready=0, all rd_data=0. Array contents are not touched by rst itself.
- CLEAR: each cycle write 0 to entry ptr, ptr++. Clearing entry DEPTH-1 moves to READY next edge; ready=1 from that edge. CLEAR lasts exactly DEPTH cycles after rst deasserts.
- READY + clear=1: go to CLEAR, ptr=0, ready=0 next edge; any write in that same cycle is still committed, then overwritten by the sweep.
- clear while in CLEAR: ignored (sweep not restarted).
- In CLEAR: wr_en ignored; rd_data forced to 0 on every edge.
- Write (READY): wr_en[p]=1 stores wr_data[p] at wr_addr[p] on the edge. Dropped if wr_addr ≥ DEPTH, or wr_addr=0 with ZERO_REG=1.
- Write collision (NUM_WR=2, same address, both enabled): port 1 wins.
- Read (READY): rd_en[r]=1 captures entry rd_addr[r] into rd_data[r] on the edge. rd_en[r]=0 holds rd_data[r] (not refreshed by later writes).
- Read value priority: 0 if addr ≥ DEPTH or (addr=0, ZERO_REG=1); else same-cycle write to that address (highest enabled write port, after drop rules) → its wr_data; else array contents.
- ZERO_REG=0: entry 0 is an ordinary register.

## Timing

- Read latency 1 cycle: address at edge N → data valid after edge N, stable until next enabled read.
- Write-to-read bypass is in the same cycle: write and read of addr A at edge N → rd_data = new data after edge N.
- Write at edge N, read issued at edge N+1 → reads stored value (no hazard).
- Reset release → ready=1 after DEPTH edges; first accepted write/read is at edge DEPTH+1.
- Async rst mid-CLEAR or mid-operation: outputs go to reset values immediately; sweep restarts from ptr=0.
- No combinational path from any input to rd_data or ready.

## Test plan

- Reset: assert rst, release; ready=0 for 32 cycles, 1 at cycle 32; read all 32 addresses → all 0x00000000.
- Write/read: write x5=0xDEADBEEF, next cycle read port0 x5, port1 x0 → 0xDEADBEEF and 0; write x0=0x1234 then read x0 → 0.
- Bypass + collision (NUM_WR=2): same cycle port0 writes x7=0x11, port1 writes x7=0x22, port0 reads x7 → rd_data0=0x22 after that edge; read again later → 0x22.
- Hold: read x3=0xAA, deassert rd_en, write x3=0xBB → rd_data stays 0xAA until rd_en reasserted, then 0xBB.
- Clear: with x9=0x55, pulse clear; writes ignored for 32 cycles, rd_data=0, ready returns after 32 cycles, x9 reads 0.
- Async reset mid-clear at sweep cycle 10 → ready=0 immediately, full 32-cycle sweep repeats after release; DEPTH=20 build: address 25 write dropped, read returns 0.

Source files
------------

// File: rtl/rv32_regfile_mp.sv
// Multi-port integer register file: NUM_RD registered read ports, NUM_WR write ports,
// same-cycle write-to-read bypass, and a sequential clear engine instead of a reset loop.
module rv32_regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    output logic                     ready,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] mem [DEPTH];

    logic [AW-1:0]   wa     [NUM_WR];
    logic [XLEN-1:0] wd     [NUM_WR];
    logic            wr_ok  [NUM_WR];
    logic [AW-1:0]   ra     [NUM_RD];
    logic [XLEN-1:0] rd_val [NUM_RD];

    // Write qualification and per-port read value with bypass (highest write port wins)
    always_comb begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wa[p]    = wr_addr[p*AW +: AW];
            wd[p]    = wr_data[p*XLEN +: XLEN];
            wr_ok[p] = wr_en[p] && (32'(wa[p]) < DEPTH) && !((ZERO_REG != 0) && (wa[p] == '0));
        end
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            ra[r]     = rd_addr[r*AW +: AW];
            rd_val[r] = '0;
            if ((32'(ra[r]) < DEPTH) && !((ZERO_REG != 0) && (ra[r] == '0))) begin
                rd_val[r] = mem[ra[r]];
                for (int unsigned p = 0; p < NUM_WR; p++) begin
                    if (wr_ok[p] && (wa[p] == ra[r])) begin
                        rd_val[r] = wd[p];
                    end
                end
            end
        end
    end

    // Storage has no reset so it can map onto RAM; the sweep owns the write port in CLEAR
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            if (!rst) begin
                mem[ptr] <= '0;
            end
        end else begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_ok[p]) begin
                    mem[wa[p]] <= wd[p];
                end
            end
        end
    end

    // Clear/ready sequencing and registered read ports
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_CLEAR;
            ptr     <= '0;
            ready   <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    rd_data <= '0;
                    ptr     <= ptr + AW'(1);
                    if (ptr == LAST) begin
                        state <= S_READY;
                        ready <= 1'b1;
                        ptr   <= '0;
                    end
                end
                default: begin
                    for (int unsigned r = 0; r < NUM_RD; r++) begin
                        if (rd_en[r]) begin
                            rd_data[r*XLEN +: XLEN] <= rd_val[r];
                        end
                    end
                    if (clear) begin
                        state <= S_CLEAR;
                        ptr   <= '0;
                        ready <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
